// File: rtl/imm_ext_arbiter_if.sv
// Handshake bundle between two immediate requesters, the extension arbiter and its consumer.
// The master modport is the requester/consumer side; the slave modport is the arbiter.
interface imm_ext_arbiter_if #(
    parameter int INWIDTH  = 16,
    parameter int OUTWIDTH = 32
);
    logic                req0_valid;
    logic [INWIDTH-1:0]  req0_imm;
    logic [1:0]          req0_mode;
    logic                req0_ready;
    logic                req1_valid;
    logic [INWIDTH-1:0]  req1_imm;
    logic [1:0]          req1_mode;
    logic                req1_ready;
    logic                out_valid;
    logic                out_ready;
    logic [OUTWIDTH-1:0] out_data;
    logic                out_id;
    logic                busy;

    modport master (
        output req0_valid, req0_imm, req0_mode,
        output req1_valid, req1_imm, req1_mode,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_id, busy
    );

    modport slave (
        input  req0_valid, req0_imm, req0_mode,
        input  req1_valid, req1_imm, req1_mode,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/imm_ext_arbiter.sv
// Two-requester round-robin immediate extender with a single registered output slot.
// Define IMMEXT_UPPER_LOAD_EN to enable mode 10 (upper-load); otherwise mode 10 sign-extends.
module imm_ext_arbiter #(
    parameter int INWIDTH  = 16,
    parameter int OUTWIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_ext_arbiter_if.slave bus
);
    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t              state;
    logic                last_grant;
    logic                out_valid_r;
    logic [OUTWIDTH-1:0] out_data_r;
    logic                out_id_r;
    logic                busy_r;

    logic                can_accept;
    logic                any_valid;
    logic                accept;
    logic                grant;
    logic [INWIDTH-1:0]  sel_imm;
    logic [1:0]          sel_mode;
    logic [OUTWIDTH-1:0] ext_data;

    // Ready is held low during reset even though the state already reads EMPTY.
    assign can_accept = (state == EMPTY) || (out_valid_r && bus.out_ready);
    assign any_valid  = bus.req0_valid || bus.req1_valid;
    assign accept     = rst_n && can_accept && any_valid;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    assign bus.req0_ready = accept && (grant == 1'b0);
    assign bus.req1_ready = accept && (grant == 1'b1);

    assign sel_imm  = grant ? bus.req1_imm  : bus.req0_imm;
    assign sel_mode = grant ? bus.req1_mode : bus.req0_mode;

    // Size casts handle OUTWIDTH == INWIDTH without zero-width replication.
    always_comb begin
        ext_data = OUTWIDTH'($signed(sel_imm));
        case (sel_mode)
            2'b01:   ext_data = OUTWIDTH'(sel_imm);
`ifdef IMMEXT_UPPER_LOAD_EN
            2'b10:   ext_data = OUTWIDTH'(sel_imm) << (OUTWIDTH - INWIDTH);
`endif
            default: ext_data = OUTWIDTH'($signed(sel_imm));
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_id_r    <= 1'b0;
            busy_r      <= 1'b0;
            last_grant  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state       <= FULL;
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                        out_data_r  <= ext_data;
                        out_id_r    <= grant;
                        last_grant  <= grant;
                    end
                end
                FULL: begin
                    if (accept) begin
                        out_data_r <= ext_data;
                        out_id_r   <= grant;
                        last_grant <= grant;
                    end else if (bus.out_ready) begin
                        state       <= EMPTY;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_id    = out_id_r;
    assign bus.busy      = busy_r;
endmodule

// File: doc/imm_ext_arbiter.md
IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 Parameter INWIDTH, default 16, immediate input width.
REQ-002 Parameter OUTWIDTH, default 32, extended output width; SHALL be >= INWIDTH.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1 each  requester N presents an immediate.
REQ-006 req0_imm / req1_imm  input  INWIDTH each  raw immediate of requester N.
REQ-007 req0_mode / req1_mode  input  2 each  00 sign-extend, 01 zero-extend, 10 upper-load, 11 reserved.
REQ-008 req0_ready / req1_ready  output  1 each  requester N accepted this cycle.
REQ-009 out_valid  output  1  out_data/out_id hold a result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_data  output  OUTWIDTH  extended result.
REQ-012 out_id  output  1  index of the requester that produced out_data.
REQ-013 busy  output  1  high while state is FULL.

Function
REQ-014 FSM states: EMPTY (no result held), FULL (result held); a single output register.
REQ-015 can_accept = (state==EMPTY) or (out_valid and out_ready); accept occurs only when can_accept and at least one req valid.
REQ-016 reqN_ready combinational: high only for the granted requester in an accept cycle; at most one ready per cycle.
REQ-017 Only one valid: that requester is granted.
REQ-018 Both valid: grant the requester not equal to last_grant; last_grant updates to the granted index on every accept.
REQ-019 A continuously valid requester SHALL be granted within two accepts (no starvation).
REQ-020 Latency: accept in cycle T -> out_valid high with result in T+1.
REQ-021 Transitions: EMPTY+accept -> FULL; FULL+drain+accept -> FULL (new result, back-to-back, 1 result/cycle); FULL+drain+no accept -> EMPTY; FULL+no drain -> FULL, outputs held stable.
REQ-022 Mode 00: out_data = din replicated sign bit din[INWIDTH-1] into upper OUTWIDTH-INWIDTH bits.
REQ-023 Mode 01: upper OUTWIDTH-INWIDTH bits zero, low bits din.
REQ-024 Mode 10: see REQ-031/032.
REQ-025 Mode 11: treated as mode 00.
REQ-026 OUTWIDTH == INWIDTH: modes 00/01 pass din unchanged.
REQ-027 reqN_imm/mode sampled only in the accept cycle; changes while not ready have no effect.

Reset
REQ-028 rst_n low asynchronously forces: state EMPTY, out_valid 0, out_data 0, out_id 0, busy 0, last_grant 1 (req0 wins first tie).
REQ-029 Reset asserted mid-transfer discards the held result; no ready asserted while rst_n low.
REQ-030 First accept possible in the first clock edge after rst_n deasserts.

Configuration
REQ-031 Macro IMMEXT_UPPER_LOAD_EN defined: mode 10 yields din in out_data[OUTWIDTH-1:OUTWIDTH-INWIDTH], remaining low bits zero.
REQ-032 Macro undefined: mode 10 treated as mode 00 (sign-extend); no upper-load logic synthesized.

Verification
REQ-033 Reset, then req0_valid=1 imm=16'h8001 mode 00, out_ready=1 -> req0_ready=1 in T, T+1 out_valid=1 out_data=32'hFFFF8001 out_id=0.
REQ-034 req1 imm=16'h8001 mode 01 -> out_data=32'h00008001 out_id=1.
REQ-035 Both valid continuously, out_ready=1, after reset -> grant order 0,1,0,1; one result per cycle, out_id alternates.
REQ-036 out_ready=0 with result 32'h00001234 held, req0 valid -> req0_ready=0, out_data stable 3 cycles; raise out_ready -> same-cycle accept, next result follows in next cycle.
REQ-037 imm=16'h1234 mode 10 -> 32'h12340000 with IMMEXT_UPPER_LOAD_EN, 32'h00001234 without.
REQ-038 rst_n low while FULL -> out_valid=0, out_data=0 immediately (asynchronous), no clock needed.
